// File: rtl/program_counter_ras_if.sv
// program_counter_ras_if
//   Groups the PC/return-stack control and status signals.
//   master : the fetch controller; drives stall/sel/targets/call and observes
//            pc and the RAS status flags.
//   slave  : the program_counter_ras block itself.
//
//   Handshake: there is no valid/ready pair. Every input is sampled on each
//   rising clk edge where stall=0. stall=1 acts as "not ready": the block
//   holds all state and ignores sel/call for that edge.
//
//   ras_count is a debug view of the internal entry count.
interface program_counter_ras_if #(
    parameter int WIDTH     = 7,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic             stall;
    logic [1:0]       sel;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic [WIDTH-1:0] pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;
    logic [CW-1:0]    ras_count;

    modport master (
        output stall, sel, branch_target, jump_target, call,
        input  pc, ras_empty, ras_full, ras_underflow, ras_count
    );

    modport slave (
        input  stall, sel, branch_target, jump_target, call,
        output pc, ras_empty, ras_full, ras_underflow, ras_count
    );
endinterface

// File: rtl/program_counter_ras.sv
// program_counter_ras
//   Program counter with a circular return-address stack (RAS).
//   Ports:
//     clk    : rising-edge clock for all state
//     reset  : synchronous, active-high reset (pc, pointer, count, underflow)
//     bus    : program_counter_ras_if.slave
//              stall, sel (0 seq, 1 branch, 2 jump, 3 return), branch_target,
//              jump_target, call -> pc, ras_empty, ras_full, ras_underflow,
//              ras_count (debug)
//   A call pushes pc+INC. Pushing while full overwrites the oldest entry.
//   A return with an empty stack falls through to pc+INC and pulses
//   ras_underflow for one cycle.
module program_counter_ras #(
    parameter int WIDTH     = 7,
    parameter int RAS_DEPTH = 4,
    parameter int INC       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    program_counter_ras_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_RETURN = 2'd3;

    logic [WIDTH-1:0] pc_q;
    logic [PW-1:0]    top_q;
    logic [CW-1:0]    count_q;
    logic             underflow_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic [WIDTH-1:0] ret_addr;
    logic             empty;
    logic             full;

    logic [WIDTH-1:0] pc_next;
    logic [PW-1:0]    top_next;
    logic [CW-1:0]    count_next;
    logic             underflow_next;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    assign ret_addr = pc_q + WIDTH'(INC);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(RAS_DEPTH));

    always_comb begin
        pc_next        = ret_addr;
        top_next       = top_q;
        count_next     = count_q;
        underflow_next = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = top_q + PW'(1);

        case (bus.sel)
            SEL_SEQ:    pc_next = ret_addr;
            SEL_BRANCH: pc_next = bus.branch_target;
            SEL_JUMP:   pc_next = bus.jump_target;
            SEL_RETURN: begin
                if (empty) begin
                    // Fall through; any simultaneous call is dropped.
                    pc_next        = ret_addr;
                    underflow_next = 1'b1;
                end else begin
                    pc_next = ras_mem[top_q];
                    if (bus.call) begin
                        // Return+call: replace the popped entry in place.
                        wr_en  = 1'b1;
                        wr_idx = top_q;
                    end else begin
                        top_next   = top_q - PW'(1);
                        count_next = count_q - CW'(1);
                    end
                end
            end
            default: pc_next = ret_addr;
        endcase

        if (bus.call && bus.sel != SEL_RETURN) begin
            // Pointer wraps naturally (power-of-two depth); when full the
            // slot at top+1 is the oldest entry, so it is overwritten.
            wr_en    = 1'b1;
            wr_idx   = top_q + PW'(1);
            top_next = top_q + PW'(1);
            if (!full) begin
                count_next = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            top_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else if (bus.stall) begin
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            top_q       <= top_next;
            count_q     <= count_next;
            underflow_q <= underflow_next;
        end
    end

    // Entry storage is not reset; entries are unreachable while count is 0.
    always_ff @(posedge clk) begin
        if (!reset && !bus.stall && wr_en) begin
            ras_mem[wr_idx] <= ret_addr;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ras_empty     = empty;
    assign bus.ras_full      = full;
    assign bus.ras_underflow = underflow_q;
    assign bus.ras_count     = count_q;
endmodule

// File: tb/tb_program_counter_ras.sv
module tb_program_counter_ras;
  localparam int WIDTH     = 7;
  localparam int RAS_DEPTH = 4;

  logic clk;
  logic reset;
  int total;
  int bad;
  logic [WIDTH-1:0] exp_q[$];

  program_counter_ras_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

  program_counter_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH), .INC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input int bt, input int jt, input logic call);
    bus.sel           = sel;
    bus.branch_target = WIDTH'(bt);
    bus.jump_target   = WIDTH'(jt);
    bus.call          = call;
  endtask

  task automatic go(input logic [1:0] sel, input int bt, input int jt, input logic call);
    drive(sel, bt, jt, call);
    step();
  endtask

  task automatic check_state(input string tag, input int pc, input int empty, input int full,
                             input int uf);
    check({tag, ".pc"}, 32'(bus.pc), pc);
    check({tag, ".empty"}, 32'(bus.ras_empty), empty);
    check({tag, ".full"}, 32'(bus.ras_full), full);
    check({tag, ".uf"}, 32'(bus.ras_underflow), uf);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    drive(2'd0, 0, 0, 1'b0);
    step();
    step();
    check_state("reset", 0, 1, 0, 0);
    check("reset.count", 32'(bus.ras_count), 0);
    reset = 1'b0;

    // sequential and wrap
    for (int i = 1; i <= 3; i++) begin
      go(2'd0, 0, 0, 1'b0);
      check("seq.pc", 32'(bus.pc), i);
    end
    go(2'd1, 127, 0, 1'b0);
    check("branch127.pc", 32'(bus.pc), 127);
    go(2'd0, 0, 0, 1'b0);
    check("wrap.pc", 32'(bus.pc), 0);

    // call and return
    go(2'd1, 5, 0, 1'b0);
    go(2'd2, 0, 40, 1'b1);
    check_state("call", 40, 0, 0, 0);
    go(2'd3, 0, 0, 1'b0);
    check_state("ret", 6, 1, 0, 0);

    // overflow: pushes of 11,21,31,41,51; 11 is overwritten
    for (int i = 1; i <= 5; i++) begin
      go(2'd1, i * 10, 0, 1'b0);
      go(2'd2, 0, 100, 1'b1);
      check("ovf.pc", 32'(bus.pc), 100);
      check("ovf.full", 32'(bus.ras_full), (i >= 4) ? 1 : 0);
      check("ovf.count", 32'(bus.ras_count), (i >= 4) ? 4 : i);
    end
    exp_q.push_back(7'd51);
    exp_q.push_back(7'd41);
    exp_q.push_back(7'd31);
    exp_q.push_back(7'd21);
    while (exp_q.size() > 0) begin
      go(2'd3, 0, 0, 1'b0);
      check("pop.pc", 32'(bus.pc), 32'(exp_q.pop_front()));
      check("pop.uf", 32'(bus.ras_underflow), 0);
    end
    check("pop.empty", 32'(bus.ras_empty), 1);
    go(2'd3, 0, 0, 1'b0);
    check_state("underflow", 22, 1, 0, 1);
    go(2'd0, 0, 0, 1'b0);
    check_state("after_uf", 23, 1, 0, 0);

    // stall
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go(2'd2, 0, 99, 1'b1);
      check_state("stall", 23, 1, 0, 0);
    end
    go(2'd3, 0, 0, 1'b0);
    check_state("stall_ret", 23, 1, 0, 0);
    bus.stall = 1'b0;

    // simultaneous return and call: stack [5, 20], pc=8
    go(2'd1, 4, 0, 1'b0);
    go(2'd2, 0, 19, 1'b1);
    go(2'd2, 0, 8, 1'b1);
    check("rc.setup.pc", 32'(bus.pc), 8);
    check("rc.setup.count", 32'(bus.ras_count), 2);
    go(2'd3, 0, 0, 1'b1);
    check("rc.pc", 32'(bus.pc), 20);
    check("rc.count", 32'(bus.ras_count), 2);
    go(2'd3, 0, 0, 1'b0);
    check("rc.ret.pc", 32'(bus.pc), 9);
    check("rc.ret.count", 32'(bus.ras_count), 1);
    go(2'd3, 0, 0, 1'b0);
    check("rc.ret2.pc", 32'(bus.pc), 5);
    check("rc.ret2.empty", 32'(bus.ras_empty), 1);

    // reset mid-operation with stall active
    go(2'd2, 0, 30, 1'b1);
    go(2'd2, 0, 60, 1'b1);
    check("mid.setup.count", 32'(bus.ras_count), 2);
    bus.stall = 1'b1;
    reset     = 1'b1;
    go(2'd3, 0, 0, 1'b1);
    check_state("mid.reset", 0, 1, 0, 0);
    check("mid.reset.count", 32'(bus.ras_count), 0);
    bus.stall = 1'b0;
    reset     = 1'b0;
    go(2'd3, 0, 0, 1'b1);
    check_state("mid.uf", 1, 1, 0, 1);
    go(2'd0, 0, 0, 1'b0);
    check_state("mid.after", 2, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
